// File: rtl/elevator_pkg.sv
// Shared elevator definitions: building geometry, dispatch cost constants,
// hall-call slot helpers and the car-index type.
// A slot numbers one hall call. Slots 0..NUM_FLOORS-1 are the up calls at
// floors 0..NUM_FLOORS-1. The next NUM_FLOORS slots are the down calls at
// floors 0..NUM_FLOORS-1.
package elevator_pkg;

  localparam int NUM_FLOORS  = 4;
  localparam int FLOOR_W     = 2;
  localparam int DIR_PENALTY = 4;

  localparam int NUM_SLOTS   = 2 * NUM_FLOORS;
  localparam int SLOT_W      = $clog2(NUM_SLOTS);
  // Wide enough for the largest floor distance plus the direction penalty.
  localparam int COST_W      = FLOOR_W + 4;

  // The top floor has no up button and the ground floor has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_VALID_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DOWN_VALID_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic {CAR0 = 1'b0, CAR1 = 1'b1} car_idx_t;

  function automatic logic slot_is_down(input logic [SLOT_W-1:0] slot);
    return slot >= SLOT_W'(NUM_FLOORS);
  endfunction

  function automatic logic [FLOOR_W-1:0] slot_floor(input logic [SLOT_W-1:0] slot);
    logic [SLOT_W-1:0] base_s;
    if (slot_is_down(slot)) begin
      base_s = slot - SLOT_W'(NUM_FLOORS);
    end else begin
      base_s = slot;
    end
    return base_s[FLOOR_W-1:0];
  endfunction

endpackage

// File: rtl/dispatch_cost.sv
// Combinational dispatch cost of sending one car to one call floor.
// The cost is the floor distance. DIR_PENALTY is added when the car is
// travelling away from the call. An idle car gets no penalty.
//   car_floor/car_up/car_down : car position and travel direction
//   call_floor                : floor of the call being evaluated
//   cost                      : resulting cost (unsigned)
module dispatch_cost #(
  parameter int FLOOR_W     = 2,
  parameter int DIR_PENALTY = 4,
  parameter int COST_W      = 6
) (
  input  logic [FLOOR_W-1:0] car_floor,
  input  logic               car_up,
  input  logic               car_down,
  input  logic [FLOOR_W-1:0] call_floor,
  output logic [COST_W-1:0]  cost
);

  logic [FLOOR_W:0] dist_s;
  logic             away_s;

  // Absolute distance without wrap, plus the moving-away penalty.
  always_comb begin
    if (call_floor >= car_floor) begin
      dist_s = {1'b0, call_floor} - {1'b0, car_floor};
    end else begin
      dist_s = {1'b0, car_floor} - {1'b0, call_floor};
    end
    away_s = (car_up && (call_floor < car_floor)) ||
             (car_down && (call_floor > car_floor));
    if (away_s) begin
      cost = COST_W'(dist_s) + COST_W'(DIR_PENALTY);
    end else begin
      cost = COST_W'(dist_s);
    end
  end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Two-car hall-call dispatcher. The block latches the hall buttons into
// per-call slots. A round-robin scan pointer assigns at most one pending call
// per cycle to the cheaper car. A call is released when its owning car opens
// its door at that floor.
//   clk, reset            : clock, synchronous active-high reset
//   hall_up, hall_down    : hall buttons, one bit per floor
//   carN_floor/up/down/door : state of car N
//   car0_req, car1_req    : floors assigned to each car (registered)
//   lamp_up, lamp_down    : pending-call lanterns (registered)
//   assign_pulse, assign_car : one-cycle strobe and the car it assigned to
module hall_call_dispatcher
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_down,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic                  car0_up,
  input  logic                  car0_down,
  input  logic                  car0_door,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car1_up,
  input  logic                  car1_down,
  input  logic                  car1_door,
  output logic [NUM_FLOORS-1:0] car0_req,
  output logic [NUM_FLOORS-1:0] car1_req,
  output logic [NUM_FLOORS-1:0] lamp_up,
  output logic [NUM_FLOORS-1:0] lamp_down,
  output logic                  assign_pulse,
  output logic                  assign_car
);

  logic [NUM_SLOTS-1:0] pending_r;
  logic [NUM_SLOTS-1:0] assigned_r;
  logic [NUM_SLOTS-1:0] owner_r;     // 1 = CAR1; valid only while assigned
  logic [SLOT_W-1:0]    scan_r;
  car_idx_t             tie_r;

  logic [NUM_SLOTS-1:0] press_s;
  logic [NUM_SLOTS-1:0] clear_s;
  logic [NUM_SLOTS-1:0] assign_mask_s;
  logic [NUM_SLOTS-1:0] pending_n_s;
  logic [NUM_SLOTS-1:0] assigned_n_s;
  logic [NUM_SLOTS-1:0] owner_n_s;
  logic [NUM_SLOTS-1:0] own0_s;
  logic [NUM_SLOTS-1:0] own1_s;
  logic [FLOOR_W-1:0]   scan_floor_s;
  logic [COST_W-1:0]    cost0_s;
  logic [COST_W-1:0]    cost1_s;
  logic                 do_assign_s;
  logic                 tie_hit_s;
  car_idx_t             chosen_s;

  assign scan_floor_s = slot_floor(scan_r);

  dispatch_cost #(.FLOOR_W(FLOOR_W), .DIR_PENALTY(DIR_PENALTY), .COST_W(COST_W)) u_cost0 (
    .car_floor (car0_floor),
    .car_up    (car0_up),
    .car_down  (car0_down),
    .call_floor(scan_floor_s),
    .cost      (cost0_s)
  );

  dispatch_cost #(.FLOOR_W(FLOOR_W), .DIR_PENALTY(DIR_PENALTY), .COST_W(COST_W)) u_cost1 (
    .car_floor (car1_floor),
    .car_up    (car1_up),
    .car_down  (car1_down),
    .call_floor(scan_floor_s),
    .cost      (cost1_s)
  );

  // Button presses and door-open clears, per slot.
  always_comb begin
    press_s = {hall_down & DOWN_VALID_MASK, hall_up & UP_VALID_MASK};
    clear_s = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      // A car releases its own calls and unowned calls, never the other car's.
      clear_s[s] = (car0_door && (car0_floor == slot_floor(SLOT_W'(s))) &&
                    (!assigned_r[s] || (owner_r[s] == CAR0))) ||
                   (car1_door && (car1_floor == slot_floor(SLOT_W'(s))) &&
                    (!assigned_r[s] || (owner_r[s] == CAR1)));
    end
  end

  // Pick the car for the scanned slot. Equal costs go to the tie car.
  always_comb begin
    tie_hit_s = 1'b0;
    if (cost0_s < cost1_s) begin
      chosen_s = CAR0;
    end else if (cost1_s < cost0_s) begin
      chosen_s = CAR1;
    end else begin
      chosen_s  = tie_r;
      tie_hit_s = 1'b1;
    end
  end

  // Next slot state. A clear overrides both a new press and an assignment.
  always_comb begin
    do_assign_s   = pending_r[scan_r] && !assigned_r[scan_r] && !clear_s[scan_r];
    assign_mask_s = {NUM_SLOTS{do_assign_s}} &
                    ({{(NUM_SLOTS-1){1'b0}}, 1'b1} << scan_r);
    pending_n_s   = (pending_r | press_s) & ~clear_s;
    assigned_n_s  = (assigned_r & ~clear_s) | assign_mask_s;
    owner_n_s     = (owner_r & ~clear_s & ~assign_mask_s) |
                    ({NUM_SLOTS{chosen_s == CAR1}} & assign_mask_s);
    own0_s        = assigned_r & ~owner_r;
    own1_s        = assigned_r & owner_r;
  end

  // Slot state, scan pointer, tie bit and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r    <= '0;
      assigned_r   <= '0;
      owner_r      <= '0;
      scan_r       <= '0;
      tie_r        <= CAR0;
      car0_req     <= '0;
      car1_req     <= '0;
      lamp_up      <= '0;
      lamp_down    <= '0;
      assign_pulse <= 1'b0;
      assign_car   <= 1'b0;
    end else begin
      pending_r  <= pending_n_s;
      assigned_r <= assigned_n_s;
      owner_r    <= owner_n_s;
      if (scan_r == SLOT_W'(NUM_SLOTS - 1)) begin
        scan_r <= '0;
      end else begin
        scan_r <= scan_r + SLOT_W'(1);
      end
      if (do_assign_s && tie_hit_s) begin
        tie_r <= (tie_r == CAR0) ? CAR1 : CAR0;
      end else begin
        tie_r <= tie_r;
      end
      // The request vectors and lanterns follow the slot state one cycle late.
      car0_req     <= own0_s[NUM_FLOORS-1:0] | own0_s[NUM_SLOTS-1:NUM_FLOORS];
      car1_req     <= own1_s[NUM_FLOORS-1:0] | own1_s[NUM_SLOTS-1:NUM_FLOORS];
      lamp_up      <= pending_r[NUM_FLOORS-1:0];
      lamp_down    <= pending_r[NUM_SLOTS-1:NUM_FLOORS];
      assign_pulse <= do_assign_s;
      assign_car   <= do_assign_s && (chosen_s == CAR1);
    end
  end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
module tb_hall_call_dispatcher;

  localparam int N   = 4;
  localparam int NS  = 2 * N;
  localparam int PEN = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] hall_up, hall_down;
  logic [1:0]   car0_floor, car1_floor;
  logic         car0_up, car0_down, car0_door;
  logic         car1_up, car1_down, car1_door;
  logic [N-1:0] car0_req, car1_req, lamp_up, lamp_down;
  logic         assign_pulse, assign_car;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per call, plus the scan position and tie car.
  int m_pend[NS];
  int m_asg[NS];
  int m_own[NS];
  int m_scan;
  int m_tie;

  logic [N-1:0] exp_req0, exp_req1, exp_lu, exp_ld;
  logic         exp_pulse, exp_car;

  hall_call_dispatcher dut (
    .clk(clk), .reset(reset), .hall_up(hall_up), .hall_down(hall_down),
    .car0_floor(car0_floor), .car0_up(car0_up), .car0_down(car0_down), .car0_door(car0_door),
    .car1_floor(car1_floor), .car1_up(car1_up), .car1_down(car1_down), .car1_door(car1_door),
    .car0_req(car0_req), .car1_req(car1_req), .lamp_up(lamp_up), .lamp_down(lamp_down),
    .assign_pulse(assign_pulse), .assign_car(assign_car)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int model_cost(int car_f, bit up, bit dn, int call_f);
    int d;
    d = (car_f > call_f) ? car_f - call_f : call_f - car_f;
    if ((up && call_f < car_f) || (dn && call_f > car_f)) d += PEN;
    return d;
  endfunction

  // Advance one clock: predict the outputs of this edge from the model, then
  // update the model with the inputs currently applied.
  task automatic tick();
    int clr[NS];
    int f, c0, c1, win;
    for (int k = 0; k < N; k++) begin
      exp_lu[k]   = (m_pend[k] != 0);
      exp_ld[k]   = (m_pend[k+N] != 0);
      exp_req0[k] = (m_asg[k] != 0 && m_own[k] == 0) || (m_asg[k+N] != 0 && m_own[k+N] == 0);
      exp_req1[k] = (m_asg[k] != 0 && m_own[k] == 1) || (m_asg[k+N] != 0 && m_own[k+N] == 1);
    end
    for (int s = 0; s < NS; s++) begin
      f = s % N;
      clr[s] = ((car0_door && int'(car0_floor) == f && (m_asg[s] == 0 || m_own[s] == 0)) ||
                (car1_door && int'(car1_floor) == f && (m_asg[s] == 0 || m_own[s] == 1))) ? 1 : 0;
    end
    exp_pulse = 1'b0;
    exp_car   = 1'b0;
    if (m_pend[m_scan] != 0 && m_asg[m_scan] == 0 && clr[m_scan] == 0) begin
      f  = m_scan % N;
      c0 = model_cost(int'(car0_floor), car0_up, car0_down, f);
      c1 = model_cost(int'(car1_floor), car1_up, car1_down, f);
      if (c0 < c1) win = 0;
      else if (c1 < c0) win = 1;
      else begin
        win   = m_tie;
        m_tie = 1 - m_tie;
      end
      m_asg[m_scan] = 1;
      m_own[m_scan] = win;
      exp_pulse = 1'b1;
      exp_car   = (win == 1);
    end
    for (int s = 0; s < NS; s++) begin
      if (clr[s] != 0) begin
        m_pend[s] = 0; m_asg[s] = 0; m_own[s] = 0;
      end else if (s < N) begin
        if (hall_up[s] && s != N - 1) m_pend[s] = 1;
      end else begin
        if (hall_down[s-N] && s != N) m_pend[s] = 1;
      end
    end
    m_scan = (m_scan + 1) % NS;
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        m_pend[s] = 0; m_asg[s] = 0; m_own[s] = 0;
      end
      m_scan = 0; m_tie = 0;
      exp_pulse = 1'b0; exp_car = 1'b0;
      exp_req0 = '0; exp_req1 = '0; exp_lu = '0; exp_ld = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hall_up = '0; hall_down = '0;
    car0_floor = 2'd0; car0_up = 1'b0; car0_down = 1'b0; car0_door = 1'b0;
    car1_floor = 2'd0; car1_up = 1'b0; car1_down = 1'b0; car1_door = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({car0_req, car1_req, lamp_up, lamp_down, assign_pulse, assign_car} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {car0_req, car1_req, lamp_up, lamp_down, assign_pulse, assign_car});
    end
  endtask

  // Wait up to 'limit' edges for an assign_pulse, checking the strobe each edge.
  task automatic wait_assign(input string name, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      checks++;
      if (assign_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL %s_pulse: got %b required %b at edge %0d", name, assign_pulse, exp_pulse, i);
      end
      if (assign_pulse === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no assign_pulse within %0d cycles", name, limit);
    end
  endtask

  task automatic test_single_call();
    bit got;
    do_reset();
    hall_up = 4'b0001;
    tick();
    hall_up = 4'b0000;
    wait_assign("single", 8, got);
    checks++;
    if (assign_car !== 1'b0 || assign_car !== exp_car) begin
      errors++;
      $display("FAIL single_car: got %b required 0", assign_car);
    end
    tick();
    checks++;
    if (car0_req !== 4'b0001 || lamp_up !== 4'b0001 || car1_req !== 4'b0000) begin
      errors++;
      $display("FAIL single_outputs: got req0 %b req1 %b lamp_up %b required 0001 0000 0001",
               car0_req, car1_req, lamp_up);
    end
    // The first call was a tie, so the next tied call goes to car 1.
    hall_up = 4'b0010;
    tick();
    hall_up = 4'b0000;
    wait_assign("tie", 2 * NS, got);
    checks++;
    if (assign_car !== 1'b1 || assign_car !== exp_car) begin
      errors++;
      $display("FAIL tie_toggle: got %b required 1", assign_car);
    end
  endtask

  task automatic test_direction_cost();
    bit got;
    do_reset();
    car0_floor = 2'd0; car0_up = 1'b1;
    car1_floor = 2'd3;
    hall_down = 4'b0100;
    tick();
    hall_down = 4'b0000;
    wait_assign("direction", 2 * NS, got);
    checks++;
    if (assign_car !== 1'b1 || assign_car !== exp_car) begin
      errors++;
      $display("FAIL direction_car: got %b required 1", assign_car);
    end
    tick();
    checks++;
    if (car1_req !== 4'b0100 || car0_req !== 4'b0000 || lamp_down !== 4'b0100) begin
      errors++;
      $display("FAIL direction_req: got req1 %b req0 %b lamp_down %b required 0100 0000 0100",
               car1_req, car0_req, lamp_down);
    end
  endtask

  task automatic test_penalty_and_service();
    bit got;
    do_reset();
    car0_floor = 2'd2; car0_up = 1'b1;
    car1_floor = 2'd0;
    hall_up = 4'b0010;
    tick();
    hall_up = 4'b0000;
    wait_assign("penalty", 2 * NS, got);
    checks++;
    if (assign_car !== 1'b1 || assign_car !== exp_car) begin
      errors++;
      $display("FAIL penalty_car: got %b required 1", assign_car);
    end
    // Car 0 opens at floor 1: the call belongs to car 1 and must survive.
    car0_floor = 2'd1; car0_up = 1'b0; car0_door = 1'b1;
    tick();
    car0_door = 1'b0;
    tick();
    checks++;
    if (car1_req !== 4'b0010 || lamp_up !== 4'b0010) begin
      errors++;
      $display("FAIL service_other_car: got req1 %b lamp_up %b required 0010 0010", car1_req, lamp_up);
    end
    car1_floor = 2'd1; car1_door = 1'b1;
    tick();
    car1_door = 1'b0;
    tick();
    checks++;
    if (car1_req !== 4'b0000 || lamp_up !== 4'b0000) begin
      errors++;
      $display("FAIL service_clear: got req1 %b lamp_up %b required 0000 0000", car1_req, lamp_up);
    end
  endtask

  task automatic test_ignored_buttons();
    do_reset();
    hall_up = 4'b1000;
    hall_down = 4'b0001;
    for (int i = 0; i < 3 * NS; i++) begin
      tick();
      checks++;
      if (lamp_up !== 4'b0000 || lamp_down !== 4'b0000 || assign_pulse !== 1'b0) begin
        errors++;
        $display("FAIL ignored_buttons: got lamp_up %b lamp_down %b pulse %b required 0 0 0",
                 lamp_up, lamp_down, assign_pulse);
      end
    end
    hall_up = '0;
    hall_down = '0;
  endtask

  task automatic test_reset_mid();
    bit got;
    int n;
    do_reset();
    hall_up = 4'b0011;
    tick();
    hall_up = 4'b0000;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      wait_assign("pre_reset", 2 * NS, got);
      if (got) n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({car0_req, car1_req, lamp_up, lamp_down, assign_pulse} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %b required all zero",
               {car0_req, car1_req, lamp_up, lamp_down, assign_pulse});
    end
    hall_up = 4'b0011;
    tick();
    hall_up = 4'b0000;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      wait_assign("re_press", 2 * NS, got);
      if (got) n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL re_press_count: got %0d assignments required 2", n);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      hall_up   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      hall_down = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 7) == 0) car0_floor = 2'($urandom);
      if ($urandom_range(0, 7) == 0) car1_floor = 2'($urandom);
      r = $urandom_range(0, 2);
      car0_up = (r == 1); car0_down = (r == 2);
      r = $urandom_range(0, 2);
      car1_up = (r == 1); car1_down = (r == 2);
      car0_door = ($urandom_range(0, 5) == 0);
      car1_door = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if ({car0_req, car1_req} !== {exp_req0, exp_req1}) begin
        errors++;
        $display("FAIL rnd_req cycle %0d: got %b_%b required %b_%b", i, car0_req, car1_req, exp_req0, exp_req1);
      end
      checks++;
      if ({lamp_up, lamp_down} !== {exp_lu, exp_ld}) begin
        errors++;
        $display("FAIL rnd_lamp cycle %0d: got %b_%b required %b_%b", i, lamp_up, lamp_down, exp_lu, exp_ld);
      end
      checks++;
      if (assign_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL rnd_pulse cycle %0d: got %b required %b", i, assign_pulse, exp_pulse);
      end
      if (exp_pulse) begin
        checks++;
        if (assign_car !== exp_car) begin
          errors++;
          $display("FAIL rnd_car cycle %0d: got %b required %b", i, assign_car, exp_car);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin
      m_pend[s] = 0; m_asg[s] = 0; m_own[s] = 0;
    end
    m_scan = 0;
    m_tie = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_call();
    test_direction_cost();
    test_penalty_and_service();
    test_ignored_buttons();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
